// File: rtl/popcount_accum.sv
// Accumulates per-nibble ones counts into a frame total, beat count and error/overflow flags.
// Latency: result valid the cycle after the last beat; backpressure: in_ready low while a result is held.
// Optional: define POPACC_SAT_EN to saturate the total on overflow instead of wrapping.
module popcount_accum #(
  parameter int SUM_W  = 8,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        in_cnt,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [SUM_W-1:0]  out_total,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_err,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_live;
  logic [SUM_W-1:0]   r_total, w_total_nxt;
  logic [BEAT_W-1:0]  r_beats, w_beats_nxt;
  logic               r_err, w_err_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               w_bad;
  logic [2:0]         w_eff;
  logic               w_accept;
  logic [SUM_W:0]     w_sum;

  assign w_bad    = (in_cnt > 3'd4);
  assign w_eff    = w_bad ? 3'd4 : in_cnt;
  // r_live keeps in_ready low until the first edge after reset release
  assign in_ready = r_live && (r_state != DONE);
  assign w_accept = in_valid && in_ready;
  // Registers are always zero in IDLE, so IDLE and ACC share one accumulate path
  assign w_sum    = {1'b0, r_total} + (SUM_W+1)'(w_eff);

  always_comb begin
    w_state_nxt = r_state;
    w_total_nxt = r_total;
    w_beats_nxt = r_beats;
    w_err_nxt   = r_err;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE, ACC: begin
        if (w_accept) begin
          w_beats_nxt = r_beats + BEAT_W'(1);
          w_err_nxt   = r_err | w_bad;
          w_ovf_nxt   = r_ovf | w_sum[SUM_W];
`ifdef POPACC_SAT_EN
          w_total_nxt = (r_ovf || w_sum[SUM_W]) ? {SUM_W{1'b1}} : w_sum[SUM_W-1:0];
`else
          w_total_nxt = w_sum[SUM_W-1:0];
`endif
          w_state_nxt = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
          w_total_nxt = '0;
          w_beats_nxt = '0;
          w_err_nxt   = 1'b0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
      r_total <= '0;
      r_beats <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      r_total <= w_total_nxt;
      r_beats <= w_beats_nxt;
      r_err   <= w_err_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign out_total = r_total;
  assign out_beats = r_beats;
  assign out_err   = r_err;
  assign out_ovf   = r_ovf;
  assign out_valid = (r_state == DONE);

endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 Parameter SUM_W, default 8, width of the accumulated ones total.
REQ-002 Parameter BEAT_W, default 8, width of the per-frame beat counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_cnt  input  3  ones count of one 4-bit nibble, legal range 0..4, from the upstream popcount stage.
REQ-006 in_valid  input  1  in_cnt and in_last are valid this cycle.
REQ-007 in_last  input  1  current beat is the final beat of the frame.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 out_total  output  SUM_W  ones total of the completed frame.
REQ-010 out_beats  output  BEAT_W  number of beats in the completed frame, modulo 2^BEAT_W.
REQ-011 out_err  output  1  at least one accepted beat in the frame had in_cnt > 4.
REQ-012 out_ovf  output  1  ones total exceeded 2^SUM_W-1 during the frame.
REQ-013 out_valid  output  1  frame result is held on the outputs.
REQ-014 out_ready  input  1  consumer takes the result this cycle.

Function
REQ-015 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-016 The FSM SHALL have states IDLE, ACC and DONE.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, 0 in DONE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE, accepted beat: total = eff_cnt, beats = 1; next state DONE if in_last, else ACC.
REQ-019 ACC, accepted beat: total += eff_cnt, beats += 1; next state DONE if in_last, else ACC.
REQ-020 eff_cnt SHALL be in_cnt for in_cnt <= 4, else 4 with out_err set (sticky until frame released).
REQ-021 No beat accepted in IDLE or ACC: all state and registers hold.
REQ-022 Latency: out_valid SHALL assert the cycle after the in_last beat is accepted; a single-beat frame completes in one cycle.
REQ-023 DONE: out_total, out_beats, out_err, out_ovf SHALL be stable while out_valid && !out_ready.
REQ-024 DONE with out_ready: next state IDLE, total, beats, err, ovf cleared to 0.
REQ-025 Beat counter SHALL wrap modulo 2^BEAT_W without flagging.
REQ-026 in_valid in DONE SHALL be ignored (no accept, no state change); new frame accepted no earlier than the cycle after release.
REQ-027 Sum SHALL be computed at SUM_W+1 bits; carry into bit SUM_W sets out_ovf (sticky for the frame).

Reset
REQ-028 rst_n low SHALL immediately force IDLE and out_total=0, out_beats=0, out_err=0, out_ovf=0, out_valid=0, in_ready=0.
REQ-029 in_ready SHALL be 1 from the first clock edge after rst_n deasserts.
REQ-030 Reset mid-frame or in DONE SHALL discard the partial or held result; no output pulse follows.

Configuration
REQ-031 Macro POPACC_SAT_EN defined: on overflow out_total SHALL saturate at 2^SUM_W-1 and hold there for the rest of the frame; out_ovf set.
REQ-032 Macro POPACC_SAT_EN undefined: out_total SHALL wrap modulo 2^SUM_W; out_ovf still set.

Verification
REQ-033 Beats 3,4,1,2(last), out_ready=1 -> out_valid one cycle after last, out_total=10, out_beats=4, err=0, ovf=0.
REQ-034 Single beat 4 with in_last -> out_valid next cycle, out_total=4, out_beats=1.
REQ-035 Frame complete, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no beat lost or accepted; release then next frame accepted.
REQ-036 Beats 2,7(last) -> out_total=6, out_err=1.
REQ-037 SUM_W=4, five beats of 4 -> with POPACC_SAT_EN out_total=15, ovf=1; without, out_total=4, ovf=1.
REQ-038 rst_n pulsed low after 2 beats of frame -> outputs zero immediately; next frame 1,1(last) -> out_total=2, out_beats=2.
